tut4_verilog_sort_iter_sorter: RTL and testbench

Iterative four-element sorter. It accepts four `p_nbits` unsigned values through a val/rdy handshake and sorts them ascending. A single shared `tut4_verilog_sort_MinMaxUnit` is reused across six sequenced compare-exchange steps, and the result is presented through a val/rdy handshake. It is the area-optimised alternative to the pipelined sort unit: one comparator, fixed latency, one sort in flight.

---
 rtl/tut4_verilog_sort_iter_sorter_pkg.sv | 25 ++
 rtl/tut4_verilog_sort_iter_sorter_minmax.sv | 16 +
 rtl/tut4_verilog_sort_iter_sorter.sv | 112 +++++++++++
 tb/tb_tut4_verilog_sort_iter_sorter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tut4_verilog_sort_iter_sorter_pkg.sv
// Shared types and step schedule for the iterative four-element sorter.
// The compare-exchange schedule is a bubble sort network folded onto one comparator.
package tut4_verilog_sort_IterSorterPkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] STEP_LAST = 3'd5;

    // Lower operand index per step; the upper operand is always the adjacent register
    localparam logic [1:0] STEP_LO_SEL [0:5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    localparam logic [1:0] STEP_HI_SEL [0:5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1};

    function automatic logic [1:0] step_lo(input logic [2:0] step);
        return (step <= STEP_LAST) ? STEP_LO_SEL[step] : 2'd0;
    endfunction

    function automatic logic [1:0] step_hi(input logic [2:0] step);
        return (step <= STEP_LAST) ? STEP_HI_SEL[step] : 2'd1;
    endfunction

endpackage

// File: rtl/tut4_verilog_sort_iter_sorter_minmax.sv
// Unsigned two-input min/max unit, shared across every compare-exchange step.
module tut4_verilog_sort_MinMaxUnit #(
    parameter int p_nbits = 8
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] out_min,
    output logic [p_nbits-1:0] out_max
);

    always_comb begin
        out_min = (in0 < in1) ? in0 : in1;
        out_max = (in0 < in1) ? in1 : in0;
    end

endmodule

// File: rtl/tut4_verilog_sort_iter_sorter.sv
// Iterative four-element ascending sorter: one shared min/max unit, six sequenced
// compare-exchange steps, val/rdy handshakes on both sides, one sort in flight.
module tut4_verilog_sort_iter_sorter
    import tut4_verilog_sort_IterSorterPkg::*;
#(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out0,
    output logic [p_nbits-1:0] out1,
    output logic [p_nbits-1:0] out2,
    output logic [p_nbits-1:0] out3
);

    state_e             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [p_nbits-1:0] r_q [4];
    logic [p_nbits-1:0] r_d [4];

    logic [1:0]         lo_sel, hi_sel;
    logic [p_nbits-1:0] opnd_lo, opnd_hi;
    logic [p_nbits-1:0] mm_min, mm_max;

    assign lo_sel  = step_lo(step_q);
    assign hi_sel  = step_hi(step_q);
    assign opnd_lo = r_q[lo_sel];
    assign opnd_hi = r_q[hi_sel];

    tut4_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_minmax (
        .in0     (opnd_lo),
        .in1     (opnd_hi),
        .out_min (mm_min),
        .out_max (mm_max)
    );

    // Handshake outputs are gated by reset so nothing is offered or accepted while held
    assign in_rdy  = reset && (state_q == ST_IDLE);
    assign out_val = reset && (state_q == ST_DONE);

    assign out0 = r_q[0];
    assign out1 = r_q[1];
    assign out2 = r_q[2];
    assign out3 = r_q[3];

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        r_d     = r_q;
        case (state_q)
            ST_IDLE: begin
                if (in_val && in_rdy) begin
                    r_d[0]  = in0;
                    r_d[1]  = in1;
                    r_d[2]  = in2;
                    r_d[3]  = in3;
                    step_d  = 3'd0;
                    state_d = ST_SORT;
                end
            end
            ST_SORT: begin
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) == lo_sel) begin
                        r_d[i] = mm_min;
                    end else if (2'(i) == hi_sel) begin
                        r_d[i] = mm_max;
                    end
                end
                if (step_q == STEP_LAST) begin
                    step_d  = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (out_val && out_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tut4_verilog_sort_iter_sorter.sv
// Directed self-checking bench for the iterative sorter: latency, ordering,
// backpressure, input held during sort, mid-sort reset and back-to-back throughput.
module tb_tut4_verilog_sort_iter_sorter;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in0, in1, in2, in3;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out0, out1, out2, out3;

    int errCount;
    int checkCount;
    int cyc;

    tut4_verilog_sort_iter_sorter #(.p_nbits(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3)
    );

    // 10-unit clock; cyc numbers the cycle that begins at each rising edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] outWord();
        return {out0, out1, out2, out3};
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Holds the set on the inputs until in_rdy is seen, then lets the accept edge pass
    task automatic applyStimulus(input logic [31:0] vec, input string tag, output int accCycle);
        int waited;
        waited = 0;
        in_val = 1'b1;
        {in0, in1, in2, in3} = vec;
        while (!in_rdy && waited < 40) begin
            nextCycle();
            waited++;
        end
        if (!in_rdy) begin
            checkOutput({tag, "_accept_timeout"}, 32'(waited), 32'd0);
        end
        accCycle = cyc;
        nextCycle();
        in_val = 1'b0;
    endtask

    // Waits for out_val and returns its cycle offset from the accept cycle
    task automatic waitResult(input int accCycle, input string tag, output int latency);
        int waited;
        waited = 0;
        while (!out_val && waited < 40) begin
            nextCycle();
            waited++;
        end
        if (!out_val) begin
            checkOutput({tag, "_result_timeout"}, 32'(waited), 32'd0);
        end
        latency = cyc - accCycle;
    endtask

    task automatic runSort(input logic [31:0] vec, input logic [31:0] expected, input string tag);
        int acc;
        int lat;
        applyStimulus(vec, tag, acc);
        waitResult(acc, tag, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd7);
        checkOutput({tag, "_data"}, outWord(), expected);
    endtask

    initial begin
        int acc;
        int lat;
        int prevAcc;
        int earlyAccepts;
        logic stableOk;

        errCount   = 0;
        checkCount = 0;
        reset      = 1'b0;
        in_val     = 1'b0;
        out_rdy    = 1'b1;
        {in0, in1, in2, in3} = '0;

        // Reset state
        nextCycle();
        nextCycle();
        checkOutput("reset_in_rdy", {31'd0, in_rdy}, 32'd0);
        checkOutput("reset_out_val", {31'd0, out_val}, 32'd0);
        checkOutput("reset_data", outWord(), 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("release_in_rdy", {31'd0, in_rdy}, 32'd1);

        // Reverse order with exact cycle timing
        applyStimulus(32'h04030201, "reverse", acc);
        checkOutput("reverse_sort_busy", {30'd0, in_rdy, out_val}, 32'd0);
        waitResult(acc, "reverse", lat);
        checkOutput("reverse_latency", 32'(lat), 32'd7);
        checkOutput("reverse_data", outWord(), 32'h01020304);
        checkOutput("reverse_done_in_rdy", {31'd0, in_rdy}, 32'd0);
        nextCycle();
        checkOutput("reverse_in_rdy_after", {31'd0, in_rdy}, 32'd1);
        checkOutput("reverse_out_val_after", {31'd0, out_val}, 32'd0);
        checkOutput("reverse_idle_hold", outWord(), 32'h01020304);

        // Duplicates and extremes
        runSort(32'hFF000500, 32'h000005FF, "extremes");
        nextCycle();
        runSort(32'h05050505, 32'h05050505, "all_equal");
        nextCycle();

        // Backpressure
        out_rdy = 1'b0;
        applyStimulus(32'h09010703, "bp", acc);
        waitResult(acc, "bp", lat);
        checkOutput("bp_latency", 32'(lat), 32'd7);
        stableOk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(out_val === 1'b1 && in_rdy === 1'b0 && outWord() === 32'h01030709)) stableOk = 1'b0;
            nextCycle();
        end
        checkOutput("bp_stable", {31'd0, stableOk}, 32'd1);
        checkOutput("bp_data", outWord(), 32'h01030709);
        out_rdy = 1'b1;
        nextCycle();
        checkOutput("bp_release_out_val", {31'd0, out_val}, 32'd0);
        checkOutput("bp_release_in_rdy", {31'd0, in_rdy}, 32'd1);

        // Input held valid with a second set during sort
        applyStimulus(32'h02040103, "held", acc);
        in_val = 1'b1;
        {in0, in1, in2, in3} = 32'h00000000;
        earlyAccepts = 0;
        for (int i = 1; i < 7; i++) begin
            if (in_rdy) earlyAccepts++;
            nextCycle();
        end
        checkOutput("held_no_early_accept", 32'(earlyAccepts), 32'd0);
        checkOutput("held_out_val", {31'd0, out_val}, 32'd1);
        checkOutput("held_data", outWord(), 32'h01020304);
        checkOutput("held_done_in_rdy", {31'd0, in_rdy}, 32'd0);
        nextCycle();
        checkOutput("held_first_idle_rdy", {31'd0, in_rdy}, 32'd1);
        prevAcc = cyc;
        checkOutput("held_second_accept_cycle", 32'(prevAcc - acc), 32'd8);
        nextCycle();
        in_val = 1'b0;
        waitResult(prevAcc, "held2", lat);
        checkOutput("held2_latency", 32'(lat), 32'd7);
        checkOutput("held2_data", outWord(), 32'h00000000);
        nextCycle();

        // Reset asserted during step 3
        applyStimulus(32'h08070605, "midreset", acc);
        nextCycle();
        nextCycle();
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("midreset_comb_in_rdy", {31'd0, in_rdy}, 32'd0);
        nextCycle();
        checkOutput("midreset_out_val", {31'd0, out_val}, 32'd0);
        checkOutput("midreset_in_rdy", {31'd0, in_rdy}, 32'd0);
        checkOutput("midreset_data", outWord(), 32'h0);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("midreset_release_rdy", {31'd0, in_rdy}, 32'd1);
        runSort(32'h03010200, 32'h00010203, "after_reset");
        nextCycle();

        // Back-to-back with out_rdy tied high
        applyStimulus(32'h06050403, "b2b0", acc);
        waitResult(acc, "b2b0", lat);
        checkOutput("b2b0_data", outWord(), 32'h03040506);
        prevAcc = acc;
        applyStimulus(32'h01010000, "b2b1", acc);
        checkOutput("b2b1_spacing", 32'(acc - prevAcc), 32'd8);
        waitResult(acc, "b2b1", lat);
        checkOutput("b2b1_data", outWord(), 32'h00000101);
        prevAcc = acc;
        applyStimulus(32'h07000700, "b2b2", acc);
        checkOutput("b2b2_spacing", 32'(acc - prevAcc), 32'd8);
        waitResult(acc, "b2b2", lat);
        checkOutput("b2b2_latency", 32'(lat), 32'd7);
        checkOutput("b2b2_data", outWord(), 32'h00000707);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
